// File: rtl/dds_cmd_decoder.sv
// DDS command decoder: turns commands delivered by the SPI receiver into DDS control registers.
// Each cmd_valid high period runs one command. The FTW is committed atomically from two halves.
module dds_cmd_decoder #(
    parameter int CMD_WIDTH  = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FTW_WIDTH  = 24
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic [CMD_WIDTH-1:0]  cmd_word,
    input  logic [DATA_WIDTH-1:0] data_word,
    input  logic                  cmd_valid,
    output logic [FTW_WIDTH-1:0]  ftw,
    output logic [7:0]            amplitude,
    output logic [1:0]            wave_sel,
    output logic                  osc_en,
    output logic                  ftw_update,
    output logic                  ftw_pending,
    output logic                  cmd_err,
    output logic [7:0]            err_count
);

    localparam int FTW_HI_W = FTW_WIDTH - 16;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EXEC     = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;

    localparam logic [CMD_WIDTH-1:0] CMD_FTW_LO     = CMD_WIDTH'(8'h01);
    localparam logic [CMD_WIDTH-1:0] CMD_FTW_HI     = CMD_WIDTH'(8'h02);
    localparam logic [CMD_WIDTH-1:0] CMD_AMP        = CMD_WIDTH'(8'h03);
    localparam logic [CMD_WIDTH-1:0] CMD_WAVE       = CMD_WIDTH'(8'h04);
    localparam logic [CMD_WIDTH-1:0] CMD_ENABLE     = CMD_WIDTH'(8'h05);
    localparam logic [CMD_WIDTH-1:0] CMD_SOFT_RESET = CMD_WIDTH'(8'h06);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = 8'hFF;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_next_s;
    logic                  valid_prev_r;
    logic                  rise_s;
    logic                  exec_s;
    logic [CMD_WIDTH-1:0]  cmd_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [15:0]           staging_r;

    assign rise_s = cmd_valid & ~valid_prev_r;
    assign exec_s = (state_r == ST_EXEC);

    // Next-state logic for the command sequencer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cmd_valid) begin
                    state_next_s = ST_WAIT_LOW;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_LOW: begin
                if (!cmd_valid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_LOW;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Sequencer state, cmd_valid history and command latch
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            // History resets high, so a level that is already high at release is not taken as a new command
            valid_prev_r <= 1'b1;
            cmd_r        <= {CMD_WIDTH{1'b0}};
            data_r       <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r      <= state_next_s;
            valid_prev_r <= cmd_valid;
            if ((state_r == ST_IDLE) && rise_s) begin
                cmd_r  <= cmd_word;
                data_r <= data_word;
            end else begin
                cmd_r  <= cmd_r;
                data_r <= data_r;
            end
        end
    end

    // Command execution into the output registers
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw         <= {FTW_WIDTH{1'b0}};
            staging_r   <= 16'h0000;
            ftw_pending <= 1'b0;
            amplitude   <= 8'hFF;
            wave_sel    <= 2'd0;
            osc_en      <= 1'b0;
            ftw_update  <= 1'b0;
            cmd_err     <= 1'b0;
            err_count   <= 8'h00;
        end else begin
            ftw_update <= 1'b0;
            cmd_err    <= 1'b0;
            if (exec_s) begin
                case (cmd_r)
                    CMD_FTW_LO: begin
                        staging_r   <= data_r[15:0];
                        ftw_pending <= 1'b1;
                    end
                    CMD_FTW_HI: begin
                        // staging_r equals ftw[15:0] when nothing is pending, so a lone high half keeps the low bits
                        ftw         <= {data_r[FTW_HI_W-1:0], staging_r};
                        ftw_pending <= 1'b0;
                        ftw_update  <= 1'b1;
                    end
                    CMD_AMP: begin
                        amplitude <= data_r[7:0];
                    end
                    CMD_WAVE: begin
                        wave_sel <= data_r[1:0];
                    end
                    CMD_ENABLE: begin
                        osc_en <= data_r[0];
                    end
                    CMD_SOFT_RESET: begin
                        ftw         <= {FTW_WIDTH{1'b0}};
                        staging_r   <= 16'h0000;
                        ftw_pending <= 1'b0;
                        amplitude   <= 8'hFF;
                        wave_sel    <= 2'd0;
                        osc_en      <= 1'b0;
                        ftw_update  <= 1'b1;
                    end
                    default: begin
                        cmd_err   <= 1'b1;
                        err_count <= sat_inc(err_count);
                    end
                endcase
            end else begin
                ftw_pending <= ftw_pending;
            end
        end
    end

endmodule

// File: tb/tb_dds_cmd_decoder.sv
// Randomised scoreboard bench for dds_cmd_decoder: stimulus pushes expected snapshots,
// and a negedge monitor pops and compares them in the cycle they are due.
module tb_dds_cmd_decoder;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cmd_word = 8'h00;
    logic [15:0] data_word = 16'h0000;
    logic        cmd_valid = 1'b0;
    logic [23:0] ftw;
    logic [7:0]  amplitude;
    logic [1:0]  wave_sel;
    logic        osc_en;
    logic        ftw_update;
    logic        ftw_pending;
    logic        cmd_err;
    logic [7:0]  err_count;

    dds_cmd_decoder dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .cmd_word(cmd_word), .data_word(data_word),
        .cmd_valid(cmd_valid), .ftw(ftw), .amplitude(amplitude), .wave_sel(wave_sel),
        .osc_en(osc_en), .ftw_update(ftw_update), .ftw_pending(ftw_pending),
        .cmd_err(cmd_err), .err_count(err_count)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       name;
        logic [23:0] ftw;
        logic [7:0]  amp;
        logic [1:0]  wave;
        logic        en;
        logic        pend;
        logic        upd;
        logic        err;
        logic [7:0]  errc;
    } rec_t;

    rec_t sb[$];
    int n_checks = 0;
    int n_pass = 0;
    int obs_upd = 0;
    int obs_err = 0;
    int both_n = 0;

    // reference model state
    int m_ftw, m_stage, m_amp, m_wave, m_en, m_pend, m_errc;
    int m_upd_n = 0;
    int m_err_n = 0;

    function automatic void model_reset_regs();
        m_ftw = 0; m_stage = 0; m_pend = 0; m_amp = 255; m_wave = 0; m_en = 0;
    endfunction

    function automatic void model_reset_all();
        model_reset_regs();
        m_errc = 0;
    endfunction

    // returns {ftw_update, cmd_err} expected for this command
    function automatic logic [1:0] model_exec(input int c, input int d);
        logic [1:0] p;
        p = 2'b00;
        case (c)
            1: begin m_stage = d; m_pend = 1; end
            2: begin m_ftw = (d % 256) * 65536 + m_stage; m_pend = 0; m_upd_n++; p = 2'b10; end
            3: m_amp = d % 256;
            4: m_wave = d % 4;
            5: m_en = d % 2;
            6: begin model_reset_regs(); m_upd_n++; p = 2'b10; end
            default: begin
                m_err_n++;
                if (m_errc < 255) m_errc++;
                p = 2'b01;
            end
        endcase
        return p;
    endfunction

    function automatic void push_rec(input int at, input string name, input logic upd, input logic err);
        rec_t r;
        r.at = at; r.name = name;
        r.ftw = 24'(m_ftw); r.amp = 8'(m_amp); r.wave = 2'(m_wave); r.en = 1'(m_en);
        r.pend = 1'(m_pend); r.upd = upd; r.err = err; r.errc = 8'(m_errc);
        sb.push_back(r);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input string name, input logic [7:0] c, input logic [15:0] d, input int hold);
        int c0;
        logic [1:0] p;
        cmd_word = c; data_word = d; cmd_valid = 1'b1; c0 = cyc;
        p = model_exec(int'(c), int'(d));
        push_rec(c0 + 2, name, p[1], p[0]);
        push_rec(c0 + 3, {name, "_after"}, 1'b0, 1'b0);
        repeat (hold) tick();
        cmd_valid = 1'b0;
        cmd_word = 8'($urandom); data_word = 16'($urandom);
        tick();
        tick();
    endtask

    function automatic logic [7:0] rand_invalid();
        logic [7:0] v;
        if ($urandom_range(0, 9) == 0) v = 8'h00;
        else v = 8'($urandom_range(7, 255));
        return v;
    endfunction

    // Monitor: pulse bookkeeping and scoreboard comparison
    always @(negedge sys_clk) begin
        rec_t r;
        if (ftw_update) obs_upd++;
        if (cmd_err) obs_err++;
        if (ftw_update && cmd_err) both_n++;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            r = sb.pop_front();
            n_checks++;
            if (r.at != cyc) begin
                $display("FAIL %s: snapshot due at cycle %0d was not compared (now %0d)", r.name, r.at, cyc);
            end else if ({ftw, amplitude, wave_sel, osc_en, ftw_pending, ftw_update, cmd_err, err_count} ===
                         {r.ftw, r.amp, r.wave, r.en, r.pend, r.upd, r.err, r.errc}) begin
                n_pass++;
            end else begin
                $display("FAIL %s @%0d: got ftw=%h amp=%h wave=%0d en=%b pend=%b upd=%b err=%b cnt=%h; expected ftw=%h amp=%h wave=%0d en=%b pend=%b upd=%b err=%b cnt=%h",
                         r.name, cyc, ftw, amplitude, wave_sel, osc_en, ftw_pending, ftw_update, cmd_err, err_count,
                         r.ftw, r.amp, r.wave, r.en, r.pend, r.upd, r.err, r.errc);
            end
        end
    end

    initial begin
        logic [7:0] c;
        int sel;
        model_reset_all();
        tick();
        tick();
        push_rec(cyc, "reset_state", 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        send("ftw_lo_4089", 8'h01, 16'h4089, 1);
        send("ftw_hi_0067", 8'h02, 16'h0067, 2);
        send("ftw_hi_only_0005", 8'h02, 16'h0005, 1);
        send("amp_1234", 8'h03, 16'h1234, 1);
        send("wave_0002", 8'h04, 16'h0002, 3);
        send("enable_0001", 8'h05, 16'h0001, 1);
        send("wave_hold20", 8'h04, 16'h0003, 20);
        send("bad_7f_hold20", 8'h7F, 16'hBEEF, 20);

        // reset while a command is in flight with cmd_valid held high across release
        send("ftw_lo_1111", 8'h01, 16'h1111, 1);
        cmd_word = 8'h03; data_word = 16'h0055; cmd_valid = 1'b1;
        tick();
        rst_n = 1'b0;
        model_reset_all();
        push_rec(cyc, "in_reset", 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        push_rec(cyc, "no_exec_after_reset", 1'b0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        send("ftw_hi_0022", 8'h02, 16'h0022, 1);

        for (int i = 0; i < 300; i++) begin
            send("bad_sat", rand_invalid(), 16'($urandom), 1);
        end
        send("soft_reset", 8'h06, 16'hFFFF, 1);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 7);
            if (sel < 6) c = 8'(sel + 1);
            else c = rand_invalid();
            send("random", c, 16'($urandom), $urandom_range(1, 4));
        end

        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d snapshots still queued", sb.size());
        end
        tick();

        n_checks++;
        if (obs_upd == m_upd_n) n_pass++;
        else $display("FAIL ftw_update_count: got %0d expected %0d", obs_upd, m_upd_n);
        n_checks++;
        if (obs_err == m_err_n) n_pass++;
        else $display("FAIL cmd_err_count: got %0d expected %0d", obs_err, m_err_n);
        n_checks++;
        if (both_n == 0) n_pass++;
        else $display("FAIL pulses_simultaneous: got %0d cycles expected 0", both_n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dds_cmd_decoder.md
DDS_CMD_DECODER -- requirements
Module: dds_cmd_decoder

Interface
REQ-001 Parameter CMD_WIDTH, default 8: command word width.
REQ-002 Parameter DATA_WIDTH, default 16: data word width.
REQ-003 Parameter FTW_WIDTH, default 24: frequency tuning word width.
REQ-004 sys_clk  input  1  single system clock; all state on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_word  input  CMD_WIDTH  command byte from the upstream SPI receiver; stable while cmd_valid is high.
REQ-007 data_word  input  DATA_WIDTH  payload from the upstream SPI receiver; stable while cmd_valid is high.
REQ-008 cmd_valid  input  1  level, high while a received command is presented; already synchronous to sys_clk.
REQ-009 ftw  output  FTW_WIDTH  active frequency tuning word to the phase accumulator.
REQ-010 amplitude  output  8  output amplitude scale.
REQ-011 wave_sel  output  2  waveform: 0 sine, 1 square, 2 triangle, 3 saw.
REQ-012 osc_en  output  1  oscillator run enable.
REQ-013 ftw_update  output  1  one-cycle pulse when ftw changes by command.
REQ-014 ftw_pending  output  1  high while a staged FTW low half awaits its high half.
REQ-015 cmd_err  output  1  one-cycle pulse on an unrecognised command.
REQ-016 err_count  output  8  saturating count of unrecognised commands.

Function
REQ-017 FSM states IDLE, EXEC and WAIT_LOW SHALL be the only states.
REQ-018 IDLE: a rising edge of cmd_valid (cmd_valid high, registered previous value low) SHALL latch cmd_word/data_word and enter EXEC.
REQ-019 EXEC SHALL last exactly one cycle, apply the latched command, then go to WAIT_LOW if cmd_valid is high, else IDLE.
REQ-020 WAIT_LOW SHALL ignore inputs and return to IDLE when cmd_valid is low; one cmd_valid high period SHALL execute exactly one command.
REQ-021 Latency: cmd_valid first sampled high at edge k SHALL yield register outputs and pulses visible after edge k+1.
REQ-022 Cmd 0x01 FTW_LO SHALL load data_word into a 16-bit staging register and set ftw_pending; ftw unchanged.
REQ-023 Cmd 0x02 FTW_HI SHALL load ftw = {data_word[7:0], staging}, clear ftw_pending and pulse ftw_update (atomic 24-bit commit).
REQ-024 FTW_HI without a preceding FTW_LO SHALL use the staging register, which always mirrors ftw[15:0] when ftw_pending is low.
REQ-025 A second FTW_LO while pending SHALL overwrite the staging register; ftw_pending stays high.
REQ-026 Cmd 0x03 AMP SHALL load amplitude = data_word[7:0].
REQ-027 Cmd 0x04 WAVE SHALL load wave_sel = data_word[1:0].
REQ-028 Cmd 0x05 ENABLE SHALL load osc_en = data_word[0].
REQ-029 Cmd 0x06 SOFT_RESET SHALL restore ftw, amplitude, wave_sel, osc_en, staging and ftw_pending to reset values, pulse ftw_update, and leave err_count unchanged.
REQ-030 Any other cmd_word SHALL change no register, pulse cmd_err and increment err_count, saturating at 255.
REQ-031 ftw_update and cmd_err SHALL be high only in the cycle after EXEC and never simultaneously.
REQ-032 Unused data_word bits SHALL be ignored.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, ftw=0, staging=0, ftw_pending=0, amplitude=0xFF, wave_sel=0, osc_en=0, ftw_update=0, cmd_err=0, err_count=0.
REQ-034 Reset asserted mid-command SHALL discard it; after release, if cmd_valid is already high, no command SHALL execute until cmd_valid goes low then high again.

Verification
REQ-035 FTW_LO 0x4089 then FTW_HI 0x0067 -> ftw_pending high after first, ftw=0x674089 with a one-cycle ftw_update after second.
REQ-036 AMP 0x1234, WAVE 0x0002, ENABLE 0x0001 -> amplitude=0x34, wave_sel=2, osc_en=1, each two edges after cmd_valid rises.
REQ-037 cmd_valid held high 20 cycles with WAVE 0x0003 -> exactly one execution; cmd 0x7F -> exactly one cmd_err pulse, err_count +1.
REQ-038 300 invalid commands -> err_count saturates at 0xFF; then SOFT_RESET -> ftw=0, amplitude=0xFF, err_count stays 0xFF.
REQ-039 FTW_LO 0x1111, then rst_n low 1 cycle while cmd_valid is high, then FTW_HI 0x0022 -> all outputs at reset values during reset; afterwards ftw=0x220000.
REQ-040 FTW_HI 0x0005 after ftw=0x674089 with no FTW_LO -> ftw=0x054089.
